fetch_unit: RTL

Instruction fetch stage of the RISC-V core. It owns the program counter, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode through a valid/ready handshake. Decode drives the control unit directly from `id_opcode`. The block also handles branch/jump redirects by flushing buffered and in-flight instructions.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: address width, base opcodes, canonical NOP
// and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// Flush has priority over push and pop; the head is read straight from storage.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full FIFO is fine as long as the head leaves in the same cycle.
    assign do_push = push && ((count_q != FULL_C) || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem_q[wr_q] <= push_data;
    end

    assign head_data = mem_q[rd_q];
    assign full      = (count_q == FULL_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, fetch FIFO, redirects.
// Define FETCH_MISALIGN_CHK_EN to fault and halt on misaligned redirect targets.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]       RESET_PC = '0,
    parameter int                    DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [6:0]       id_opcode,
    output logic             fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = XLEN + 32;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pcq_q [DEPTH];
    logic [AW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FW-1:0]   fifo_head;
    logic [XLEN-1:0] target_pc;
    logic            target_bad;
    logic            credit_ok, req_fire;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target_pc  = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    assign target_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign target_bad = 1'b0;
`endif

    // Every issued request must already own a FIFO slot for its response.
    assign credit_ok = !fifo_full &&
        (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
    assign imem_req_valid = (state_q == ST_RUN) && credit_ok && !redirect_valid;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fifo_push      = imem_rsp_valid && !redirect_valid && (discard_q == '0);
    assign fifo_pop       = id_valid && id_ready && !redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fault_d       = fault_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;

        if (state_q == ST_BOOT) state_d = ST_RUN;

        if (req_fire) begin
            pc_d          = pc_q + XLEN'(4);
            outstanding_d = outstanding_d + 1'b1;
            pcq_wr_d      = pcq_wr_q + 1'b1;
        end

        if (imem_rsp_valid) begin
            outstanding_d = outstanding_d - 1'b1;
            pcq_rd_d      = pcq_rd_q + 1'b1;
            if (!redirect_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end

        // No request fires in a redirect cycle, so outstanding_d already excludes
        // exactly the response (if any) being dropped right now.
        if (redirect_valid) begin
            pc_d      = target_pc;
            discard_d = outstanding_d;
            if (target_bad) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fault_q       <= 1'b0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fault_q       <= fault_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && req_fire) pcq_q[pcq_wr_q] <= pc_q;
    end

    fetch_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data ({pcq_q[pcq_rd_q], imem_rsp_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_req_addr = pc_q;
    assign id_valid      = !fifo_empty;
    assign id_instr      = fifo_head[31:0];
    assign id_pc         = fifo_head[FW-1:32];
    assign id_opcode     = fifo_head[6:0];
    assign fetch_fault   = fault_q;

endmodule
